// File: rtl/game_ctrl_pkg.sv
// Shared types and defaults for the memory-game control unit.
package game_ctrl_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned HOLD_CYCLES_DEF = 250000000;
  localparam int unsigned CNT_W_DEF       = 28;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_START     = 3'd2,
    ST_PLAY_FPGA = 3'd3,
    ST_PLAY_USER = 3'd4,
    ST_CHECK     = 3'd5,
    ST_NEXT      = 3'd6,
    ST_RESULT    = 3'd7
  } state_t;

  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } cmd_t;

  // Datapath command word driven while sitting in a given state.
  function automatic cmd_t state_cmd(state_t s);
    cmd_t c;
    c = '0;
    case (s)
      ST_INIT:      begin c.r1 = 1'b1; c.r2 = 1'b1; end
      ST_SETUP:     c.e1  = 1'b1;
      ST_START:     c.r2  = 1'b1;
      ST_PLAY_FPGA: c.e3  = 1'b1;
      ST_PLAY_USER: c.e2  = 1'b1;
      ST_NEXT:      c.e4  = 1'b1;
      ST_RESULT:    c.sel = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Command/status lines between the game controller and its datapath.
interface game_controller_if;

  logic r1;
  logic r2;
  logic e1;
  logic e2;
  logic e3;
  logic e4;
  logic sel;

  logic end_fpga;
  logic end_user;
  logic end_time;
  logic win;
  logic match;

  modport master (
    output r1, r2, e1, e2, e3, e4, sel,
    input  end_fpga, end_user, end_time, win, match
  );

  modport slave (
    input  r1, r2, e1, e2, e3, e4, sel,
    output end_fpga, end_user, end_time, win, match
  );

endinterface

// File: rtl/btn_edge_sync.sv
// Synchronises an active-low push button and emits one pulse per press.
module btn_edge_sync #(
  parameter int unsigned P_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pulse
);

  logic [P_STAGES-1:0] sync;
  logic                prev;

  // Flops reset to the released level so reset exit never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '1;
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[P_STAGES-2:0], btn_n};
      prev  <= sync[P_STAGES-1];
      pulse <= prev & ~sync[P_STAGES-1];
    end
  end

endmodule

// File: rtl/game_controller.sv
// Moore sequencer for the memory game.
// Optional GAME_CTRL_AUTO_RESTART_EN: RESULT auto-returns to INIT after P_HOLD_CYCLES.
module game_controller
  import game_ctrl_pkg::*;
#(
  parameter int unsigned P_SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned P_HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned P_CNT_W       = CNT_W_DEF
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               enter_n,
  game_controller_if.master  bus,
  output logic [2:0]         state_o
);

  if (P_SYNC_STAGES < 2 || P_CNT_W == 0 || P_CNT_W > 63 ||
      (64'(1) << P_CNT_W) <= 64'(P_HOLD_CYCLES)) begin : g_param_check
    $error("game_controller: illegal parameter combination");
  end

  state_t state;
  state_t state_nxt;
  cmd_t   cmd;
  logic   enter_p;
  logic   hold_done;

  btn_edge_sync #(.P_STAGES(P_SYNC_STAGES)) u_enter_sync (
    .clk   (clock_50),
    .rst   (reset),
    .btn_n (enter_n),
    .pulse (enter_p)
  );

`ifdef GAME_CTRL_AUTO_RESTART_EN
  logic [P_CNT_W-1:0] hold_cnt;

  // Held at zero outside RESULT, so it restarts on every entry; stops at terminal count.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state != ST_RESULT) begin
      hold_cnt <= '0;
    end else if (hold_cnt != P_CNT_W'(P_HOLD_CYCLES - 1)) begin
      hold_cnt <= hold_cnt + P_CNT_W'(1);
    end
  end

  assign hold_done = (state == ST_RESULT) && (hold_cnt == P_CNT_W'(P_HOLD_CYCLES - 1));
`else
  assign hold_done = 1'b0;
`endif

  function automatic state_t fsm_next(state_t s, logic ent, logic ef, logic eu,
                                      logic et, logic w, logic m, logic hd);
    state_t n;
    n = s;
    case (s)
      ST_INIT:      n = ST_SETUP;
      ST_SETUP:     if (ent) n = ST_START;
      ST_START:     n = w ? ST_RESULT : ST_PLAY_FPGA;
      ST_PLAY_FPGA: if (ef) n = ST_PLAY_USER;
      ST_PLAY_USER: if (et) n = ST_RESULT;
                    else if (eu) n = ST_CHECK;
      ST_CHECK:     n = m ? ST_NEXT : ST_RESULT;
      ST_NEXT:      n = ST_START;
      ST_RESULT:    if (ent || hd) n = ST_INIT;
      default:      n = ST_INIT;
    endcase
    return n;
  endfunction

  assign state_nxt = fsm_next(state, enter_p, bus.end_fpga, bus.end_user,
                              bus.end_time, bus.win, bus.match, hold_done);

  // Command word is registered alongside the state it belongs to.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cmd   <= state_cmd(ST_INIT);
    end else begin
      state <= state_nxt;
      cmd   <= state_cmd(state_nxt);
    end
  end

  assign bus.r1  = cmd.r1;
  assign bus.r2  = cmd.r2;
  assign bus.e1  = cmd.e1;
  assign bus.e2  = cmd.e2;
  assign bus.e3  = cmd.e3;
  assign bus.e4  = cmd.e4;
  assign bus.sel = cmd.sel;
  assign state_o = 3'(state);

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller; expected states are queued per cycle.
`timescale 1ns/1ps
module tb_game_controller;
  import game_ctrl_pkg::*;

  logic       clock_50;
  logic       reset;
  logic       enter_n;
  logic [2:0] state_o;

  game_controller_if bus ();

  game_controller #(
    .P_SYNC_STAGES (2),
    .P_HOLD_CYCLES (10),
    .P_CNT_W       (4)
  ) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .enter_n  (enter_n),
    .bus      (bus.master),
    .state_o  (state_o)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  state_t exp_q[$];
  state_t exp_s;
  int     n_checks;
  int     n_fails;
  logic   done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // {r1,r2,e1,e2,e3,e4,sel} required in each state
  function automatic logic [6:0] exp_cmd(state_t s);
    case (s)
      ST_INIT:      return 7'b1100000;
      ST_SETUP:     return 7'b0010000;
      ST_START:     return 7'b0100000;
      ST_PLAY_FPGA: return 7'b0000100;
      ST_PLAY_USER: return 7'b0001000;
      ST_CHECK:     return 7'b0000000;
      ST_NEXT:      return 7'b0000010;
      ST_RESULT:    return 7'b0000001;
      default:      return 7'b0000000;
    endcase
  endfunction

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  always @(negedge clock_50) begin
    if (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      check("state", 32'(state_o), 32'(exp_s));
      check("cmd", 32'({bus.r1, bus.r2, bus.e1, bus.e2, bus.e3, bus.e4, bus.sel}),
            32'(exp_cmd(exp_s)));
    end else if (done) begin
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
    end
  end

  task automatic tick(input state_t s);
    @(posedge clock_50);
    #1;
    exp_q.push_back(s);
  endtask

  task automatic ticks(input state_t s, input int n);
    for (int i = 0; i < n; i++) tick(s);
  endtask

  // Press lands as a pulse on the 3rd edge; state moves on the 4th.
  task automatic press_from(input state_t cur, input state_t n1, input state_t n2);
    enter_n = 1'b0;
    ticks(cur, 3);
    tick(n1);
    tick(n2);
    enter_n = 1'b1;
  endtask

  task automatic reset_now();
    @(posedge clock_50);
    #1;
    reset = 1'b1;
    exp_q.push_back(ST_INIT);
    tick(ST_INIT);
    reset = 1'b0;
    tick(ST_SETUP);
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    done         = 1'b0;
    reset        = 1'b1;
    enter_n      = 1'b1;
    bus.end_fpga = 1'b0;
    bus.end_user = 1'b0;
    bus.end_time = 1'b0;
    bus.win      = 1'b0;
    bus.match    = 1'b0;

    // Reset, then idle: one INIT cycle and no stray pulse in SETUP
    ticks(ST_INIT, 2);
    reset = 1'b0;
    ticks(ST_SETUP, 5);

    // Long press in SETUP: exactly one START then PLAY_FPGA
    enter_n = 1'b0;
    ticks(ST_SETUP, 3);
    tick(ST_START);
    ticks(ST_PLAY_FPGA, 96);
    enter_n = 1'b1;
    ticks(ST_PLAY_FPGA, 3);

    // Successful round: CHECK -> NEXT -> START -> PLAY_FPGA
    bus.end_fpga = 1'b1; tick(ST_PLAY_USER);
    bus.end_fpga = 1'b0; tick(ST_PLAY_USER);
    bus.end_user = 1'b1; bus.match = 1'b1; tick(ST_CHECK);
    bus.end_user = 1'b0; tick(ST_NEXT);
    bus.match = 1'b0; tick(ST_START);
    tick(ST_PLAY_FPGA);

    // end_time and end_user together: timeout wins
    bus.end_fpga = 1'b1; tick(ST_PLAY_USER);
    bus.end_fpga = 1'b0; bus.end_time = 1'b1; bus.end_user = 1'b1; tick(ST_RESULT);
    bus.end_time = 1'b0; bus.end_user = 1'b0;
    ticks(ST_RESULT, 3);
    press_from(ST_RESULT, ST_INIT, ST_SETUP);
    ticks(ST_SETUP, 4);

    // win at START goes straight to RESULT
    bus.win = 1'b1;
    press_from(ST_SETUP, ST_START, ST_RESULT);
    bus.win = 1'b0;
    ticks(ST_RESULT, 3);
    press_from(ST_RESULT, ST_INIT, ST_SETUP);
    ticks(ST_SETUP, 4);

    // Press ignored in PLAY_USER, then mismatch in CHECK
    press_from(ST_SETUP, ST_START, ST_PLAY_FPGA);
    ticks(ST_PLAY_FPGA, 4);
    bus.end_fpga = 1'b1; tick(ST_PLAY_USER);
    bus.end_fpga = 1'b0;
    enter_n = 1'b0; ticks(ST_PLAY_USER, 5);
    enter_n = 1'b1; ticks(ST_PLAY_USER, 4);
    bus.end_user = 1'b1; bus.match = 1'b0; tick(ST_CHECK);
    tick(ST_RESULT);
    bus.end_user = 1'b0;
    ticks(ST_RESULT, 3);
    press_from(ST_RESULT, ST_INIT, ST_SETUP);
    ticks(ST_SETUP, 4);

    // Reset mid-game returns to INIT immediately
    press_from(ST_SETUP, ST_START, ST_PLAY_FPGA);
    ticks(ST_PLAY_FPGA, 4);
    bus.end_fpga = 1'b1; tick(ST_PLAY_USER);
    bus.end_fpga = 1'b0;
    reset_now();
    ticks(ST_SETUP, 4);

`ifdef GAME_CTRL_AUTO_RESTART_EN
    // Hold of 10 cycles in RESULT, then INIT
    bus.win = 1'b1;
    press_from(ST_SETUP, ST_START, ST_RESULT);
    bus.win = 1'b0;
    ticks(ST_RESULT, 9);
    tick(ST_INIT);
    ticks(ST_SETUP, 4);

    // Reset after 5 RESULT cycles; next visit gets a full fresh hold
    bus.win = 1'b1;
    press_from(ST_SETUP, ST_START, ST_RESULT);
    bus.win = 1'b0;
    ticks(ST_RESULT, 4);
    reset_now();
    ticks(ST_SETUP, 4);
    bus.win = 1'b1;
    press_from(ST_SETUP, ST_START, ST_RESULT);
    bus.win = 1'b0;
    ticks(ST_RESULT, 9);
    tick(ST_INIT);
    ticks(ST_SETUP, 2);
`else
    // Without auto-restart RESULT waits for a press indefinitely
    bus.win = 1'b1;
    press_from(ST_SETUP, ST_START, ST_RESULT);
    bus.win = 1'b0;
    ticks(ST_RESULT, 20);
    press_from(ST_RESULT, ST_INIT, ST_SETUP);
    ticks(ST_SETUP, 2);
`endif

    done = 1'b1;
  end

endmodule
